// File: rtl/trig_ser_pkg.sv
// Shared types and constants for the trigger-paced serializer.
package trig_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic SDO_IDLE = 1'b1;

  // Number of ticks from acceptance to return to IDLE.
  function automatic int frame_ticks(input int data_w, input int parity_en);
    return 2 + data_w + parity_en;
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Falling-edge detector on the divider trigger; tick is combinational off a registered history bit.
// History resets to 0 so no tick is produced straight out of reset.
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic tick
);

  logic trig_q;
  logic trig_d;

  always_comb trig_d = trigger;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign tick = trig_q & ~trigger;

endmodule

// File: rtl/trig_serializer.sv
// UART-style serializer paced by divider ticks: start bit, DATA_W data bits, optional even parity, stop bit.
// Clears the divider (nul) when a word is accepted so the start bit gets a full bit period.
module trig_serializer
  import trig_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              sdo,
  output logic              done,
  output logic              nul
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  logic tick;

  tick_edge_det u_tick (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .tick    (tick)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              sdo_q, sdo_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              nul_q, nul_d;

  logic              bit_out;
  logic [DATA_W-1:0] shift_adv;

  // The outgoing bit always sits at the head of the shift register.
  always_comb begin
    if (MSB_FIRST) begin
      bit_out   = shift_q[DATA_W-1];
      shift_adv = shift_q << 1;
    end else begin
      bit_out   = shift_q[0];
      shift_adv = shift_q >> 1;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    nul_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sdo_d = SDO_IDLE;
        if (start) begin
          state_d = START;
          shift_d = data;
          cnt_d   = '0;
          par_d   = PARITY_EN ? ^data : 1'b0;
          sdo_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          nul_d   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          sdo_d   = bit_out;
          shift_d = shift_adv;
          cnt_d   = CW'(1);
        end
      end
      DATA: begin
        // cnt_q counts data bits already placed on sdo.
        if (tick) begin
          if (cnt_q == CW'(DATA_W)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              sdo_d   = par_q;
            end else begin
              state_d = STOP;
              sdo_d   = 1'b1;
            end
          end else begin
            sdo_d   = bit_out;
            shift_d = shift_adv;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          sdo_d   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          sdo_d   = SDO_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = SDO_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sdo_q   <= SDO_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      nul_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      nul_q   <= nul_d;
    end
  end

  assign sdo   = sdo_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign nul   = nul_q;

endmodule
